mem_bus_master: RTL

Initiator for the shared single-port memory bus. The memory side has strobes wr/rd, an address, and one bidirectional data bus. The memory writes on the clk edge while wr is high and drives data combinationally while rd is high. This block turns a valid/ready burst request interface into registered bus cycles, owns the tristate data driver, and inserts a turnaround cycle after every transaction.

---
 rtl/mem_bus_master_pkg.sv | 21 ++
 rtl/mem_bus_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_master_pkg
// Shared definitions for the single-port memory bus initiator and the memory
// it talks to: default bus widths and the master state encoding.
// ----------------------------------------------------------------------------
package mem_bus_master_pkg;

  // Default widths, shared so the master and the memory agree.
  localparam int DEF_AWIDTH = 5;  // memory address width
  localparam int DEF_DWIDTH = 8;  // data bus width
  localparam int DEF_LWIDTH = 3;  // burst length field width (beats - 1)

  // Master bus state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a burst request
    ST_WR   = 2'd1,  // issuing write beats as write data arrives
    ST_RD   = 2'd2,  // issuing read beats, one per cycle
    ST_TURN = 2'd3   // single bus turnaround cycle after every burst
  } state_t;

endpackage : mem_bus_master_pkg

// File: rtl/mem_bus_master.sv
// ----------------------------------------------------------------------------
// mem_bus_master
// Initiator for the shared single-port memory bus. Converts a valid/ready burst
// request into registered wr/rd strobe cycles, owns the tristate driver on the
// bidirectional data bus and inserts one turnaround cycle after each burst.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     burst request handshake (ready only in IDLE)
//   req_write           1 = write burst, 0 = read burst
//   req_addr, req_len   start address, beats minus one
//   wd_valid/ready/data write beat stream (ready only in WR)
//   rd_valid/data/last  captured read beats, no backpressure
//   busy                high whenever the master is not IDLE
//   mem_wr, mem_rd      registered memory strobes
//   mem_addr            registered memory address
//   mem_data            bidirectional data bus, driven only while oe is set
// ----------------------------------------------------------------------------
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  // burst request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  // write data
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DWIDTH-1:0] wd_data,
  // read data
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_last,
  // status
  output logic              busy,
  // memory bus
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  state_t              r_state;
  logic [AWIDTH-1:0]   r_cur_addr;  // next address to issue, wraps naturally
  logic [LWIDTH-1:0]   r_len;       // beats minus one for the active burst
  logic [LWIDTH-1:0]   r_cnt;       // beats issued so far in the active burst
  logic                r_last_iss;  // final read beat is on the bus this cycle
  logic                r_oe;        // data bus driver enable
  logic [DWIDTH-1:0]   r_dout;      // data driven onto the bus while r_oe
  logic                r_mem_wr;
  logic                r_mem_rd;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic                r_rd_valid;
  logic [DWIDTH-1:0]   r_rd_data;
  logic                r_rd_last;

  // The only driver this block puts on the shared bus.
  assign mem_data = r_oe ? r_dout : {DWIDTH{1'bz}};

  // Status decodes. req_ready is held low while reset is asserted so that
  // every output reads 0 during reset, even though the state is IDLE.
  assign req_ready = rst_n && (r_state == ST_IDLE);
  assign wd_ready  = (r_state == ST_WR);
  assign busy      = (r_state != ST_IDLE);

  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;

  // NOTE: all state below is updated with non-blocking assignments so that
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_last_iss <= 1'b0;
      r_oe       <= 1'b0;
      r_dout     <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      // Read capture runs in every state: the memory drives mem_data during
      // the cycle mem_rd is high, so the beat lands one edge after issue.
      r_rd_valid <= r_mem_rd;
      r_rd_last  <= r_mem_rd && r_last_iss;
      if (r_mem_rd) begin
        r_rd_data <= mem_data;
      end

      case (r_state)
        ST_IDLE: begin
          r_mem_wr <= 1'b0;
          r_mem_rd <= 1'b0;
          if (req_valid) begin
            r_cur_addr <= req_addr;
            r_len      <= req_len;
            r_cnt      <= '0;
            r_last_iss <= 1'b0;
            r_state    <= req_write ? ST_WR : ST_RD;
          end
        end

        ST_WR: begin
          if (wd_valid) begin
            r_mem_wr   <= 1'b1;
            r_mem_addr <= r_cur_addr;
            r_dout     <= wd_data;
            r_oe       <= 1'b1;
            r_cur_addr <= r_cur_addr + AWIDTH'(1);
            r_cnt      <= r_cnt + LWIDTH'(1);
            if (r_cnt == r_len) begin
              r_state <= ST_TURN;
            end
          end else begin
            // Stall beat: drop the strobe but keep driving the last data.
            r_mem_wr <= 1'b0;
          end
        end

        ST_RD: begin
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_cur_addr;
          r_cur_addr <= r_cur_addr + AWIDTH'(1);
          r_cnt      <= r_cnt + LWIDTH'(1);
          if (r_cnt == r_len) begin
            r_last_iss <= 1'b1;
            r_state    <= ST_TURN;
          end
        end

        ST_TURN: begin
          // Release the bus; the next cycle has no driver in either direction.
          r_mem_wr   <= 1'b0;
          r_mem_rd   <= 1'b0;
          r_oe       <= 1'b0;
          r_last_iss <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : mem_bus_master
